// File: rtl/video_pkg.sv
// Shared constants and types for the parametrised video pixel generator.
// Polarity bit map, underrun fill word and a reference VGA timing set.
package video_pkg;

  localparam int POL_HS = 0;
  localparam int POL_VS = 1;
  localparam int POL_BL = 2;
  localparam int POL_DE = 3;

  localparam int unsigned UDR_FILL = 0;

  typedef struct packed {
    logic [7:0]  hsync;
    logic [7:0]  hgdel;
    logic [15:0] hgate;
    logic [15:0] hlen;
    logic [7:0]  vsync;
    logic [7:0]  vgdel;
    logic [15:0] vgate;
    logic [15:0] vlen;
  } vtiming_t;

  // 640x480@60: every field is the region length minus one
  localparam vtiming_t VGA_640X480 = '{
    hsync: 8'd95,
    hgdel: 8'd47,
    hgate: 16'd639,
    hlen:  16'd799,
    vsync: 8'd1,
    vgdel: 8'd32,
    vgate: 16'd479,
    vlen:  16'd524
  };

endpackage

// File: rtl/video_pix_fifo.sv
// Pixel word FIFO between the frame-buffer reader and the output stage.
// Power-of-two depth, extra pointer bit tells full from empty.
module video_pix_fifo
  import video_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/video_pixel_gen_p.sv
// Video pixel generator: pixel divider, h/v timing, pixel FIFO,
// output polarity and test-pattern source in a single clock domain.
module video_pixel_gen_p
  import video_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int CNT_W      = 16,
  parameter int SYNC_W     = 8,
  parameter int PCLK_DIV   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_ven,
  input  logic [3:0]        ctrl_pol,
  input  logic              ctrl_tpg,
  input  logic              ctrl_clr_udr,
  input  logic [SYNC_W-1:0] Thsync,
  input  logic [SYNC_W-1:0] Thgdel,
  input  logic [CNT_W-1:0]  Thgate,
  input  logic [CNT_W-1:0]  Thlen,
  input  logic [SYNC_W-1:0] Tvsync,
  input  logic [SYNC_W-1:0] Tvgdel,
  input  logic [CNT_W-1:0]  Tvgate,
  input  logic [CNT_W-1:0]  Tvlen,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              pclk_ena,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              daten,
  output logic [DATA_W-1:0] pdata,
  output logic              eoh,
  output logic              eov,
  output logic              underrun
);

  localparam int DW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam int XW = CNT_W + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);

  logic [DW-1:0]     div_cnt;
  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  vcnt;
  logic [XW-1:0]     hx;
  logic [XW-1:0]     vx;
  logic [XW-1:0]     hs;
  logic [XW-1:0]     he;
  logic [XW-1:0]     vs;
  logic [XW-1:0]     ve;
  logic [XW-1:0]     tpg_off;
  logic              h_sync;
  logic              v_sync;
  logic              h_gate;
  logic              v_gate;
  logic              gate;
  logic              h_end;
  logic              v_end;
  logic              pop_req;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_flush;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] pix_next;

  assign pclk_ena = ctrl_ven && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || !ctrl_ven) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // >= so that a shortened Thlen/Tvlen mid-frame still wraps
  assign h_end = (hcnt >= Thlen);
  assign v_end = (vcnt >= Tvlen);

  always_ff @(posedge clk) begin
    if (rst || !ctrl_ven) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pclk_ena) begin
      if (h_end) begin
        hcnt <= '0;
        vcnt <= v_end ? '0 : vcnt + CNT_W'(1);
      end else begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end

  assign hx = XW'(hcnt);
  assign vx = XW'(vcnt);
  assign hs = XW'(Thsync) + XW'(Thgdel) + XW'(2);
  assign he = hs + XW'(Thgate);
  assign vs = XW'(Tvsync) + XW'(Tvgdel) + XW'(2);
  assign ve = vs + XW'(Tvgate);

  assign h_sync  = (hx <= XW'(Thsync));
  assign v_sync  = (vx <= XW'(Tvsync));
  assign h_gate  = (hx >= hs) && (hx <= he);
  assign v_gate  = (vx >= vs) && (vx <= ve);
  assign gate    = h_gate && v_gate;
  assign tpg_off = hx - hs;

  assign fifo_flush = !ctrl_ven;
  assign load_ready = !fifo_full && ctrl_ven;
  assign fifo_push  = load_valid && load_ready;
  assign pop_req    = pclk_ena && gate && !ctrl_tpg;
  assign fifo_pop   = pop_req && !fifo_empty;

  video_pix_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (load_data),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // an empty FIFO never forwards a same-cycle push
  always_comb begin
    pix_next = '0;
    if (gate) begin
      if (ctrl_tpg) begin
        pix_next = DATA_W'(tpg_off);
      end else if (!fifo_empty) begin
        pix_next = fifo_data;
      end else begin
        pix_next = DATA_W'(UDR_FILL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      blank <= 1'b0;
      daten <= 1'b0;
      pdata <= '0;
      eoh   <= 1'b0;
      eov   <= 1'b0;
    end else if (!ctrl_ven) begin
      hsync <= ctrl_pol[POL_HS];
      vsync <= ctrl_pol[POL_VS];
      blank <= ~ctrl_pol[POL_BL];
      daten <= ctrl_pol[POL_DE];
      pdata <= '0;
      eoh   <= 1'b0;
      eov   <= 1'b0;
    end else begin
      eoh <= pclk_ena && h_end;
      eov <= pclk_ena && h_end && v_end;
      if (pclk_ena) begin
        hsync <= h_sync ^ ctrl_pol[POL_HS];
        vsync <= v_sync ^ ctrl_pol[POL_VS];
        blank <= ~gate ^ ctrl_pol[POL_BL];
        daten <= gate ^ ctrl_pol[POL_DE];
        pdata <= pix_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ctrl_clr_udr) begin
      underrun <= 1'b0;
    end else if (pop_req && fifo_empty) begin
      underrun <= 1'b1;
    end
  end

endmodule
